traffick_lights_fsm: RTL and testbench
======================================

TRAFFICK_LIGHTS_FSM -- requirements
Module: traffick_lights_fsm

Interface
- Parameters (name, default, meaning):
  - REQ-001 The module SHALL provide the parameter YELLOW_CYCLES, default 1, giving the number of clock cycles each yellow phase lasts; legal range is 1..255.
- Ports (name, direction, width, meaning):
  - REQ-002 The module SHALL have the port clk, input, 1 bit, the single clock; all state updates occur on its rising edge.
  - REQ-003 The module SHALL have the port reset, input, 1 bit, reset that is asynchronous and active-high.
  - REQ-004 The module SHALL have the port TA, input, 1 bit, the traffic sensor for street A (1 = traffic present).
  - REQ-005 The module SHALL have the port TB, input, 1 bit, the traffic sensor for street B (1 = traffic present).
  - REQ-006 The module SHALL have the port LA, output, 2 bits, the light for street A.
  - REQ-007 The module SHALL have the port LB, output, 2 bits, the light for street B.
- REQ-008 Port order SHALL be clk, reset, TA, TB, LA, LB, so that positional instantiation works.
- REQ-009 Light encoding SHALL be GREEN=2'b00, YELLOW=2'b01, RED=2'b10; 2'b11 SHALL never be driven.

Function
- REQ-010 The block SHALL be a Moore FSM: LA and LB are decoded from the state register only, with no combinational path from TA or TB.
- REQ-011 The FSM SHALL have these states and outputs:
  - S0: LA=GREEN, LB=RED
  - S1: LA=YELLOW, LB=RED
  - S2: LA=RED, LB=GREEN
  - S3: LA=RED, LB=YELLOW
- REQ-012 In S0: TA=1 stays in S0; TA=0 moves to S1 on the next rising edge. TB is ignored.
- REQ-013 In S1: the FSM stays for exactly YELLOW_CYCLES cycles, then moves to S2 regardless of TA and TB.
- REQ-014 In S2: TB=1 stays in S2; TB=0 moves to S3 on the next rising edge. TA is ignored.
- REQ-015 In S3: the FSM stays for exactly YELLOW_CYCLES cycles, then moves to S0 regardless of TA and TB.
- REQ-016 Yellow timing:
  - A down-counter SHALL be loaded with YELLOW_CYCLES-1 on entry to S1 or S3.
  - The FSM SHALL advance when the counter reads 0.
  - With the default value, S1 and S3 each last one cycle.
- REQ-017 Any illegal state encoding SHALL transition to S0 on the next rising edge, and LA=GREEN, LB=RED SHALL be output while in it.
- REQ-018 Both lights SHALL never be non-RED simultaneously in any cycle.
- REQ-019 Unknown (X) values on TA or TB SHALL not corrupt the state encoding; they are treated as 0.

Reset
- REQ-020 Asserting reset SHALL force the state to S0 and the counter to 0 immediately, without waiting for a clock edge, giving LA=2'b00 and LB=2'b10.
- REQ-021 While reset is high, the state SHALL remain S0 regardless of clk, TA or TB.
- REQ-022 After reset deasserts, the first transition SHALL occur on the first rising edge of clk.
- REQ-023 Reset asserted mid-sequence (S1, S2, S3, or mid-yellow count) SHALL abort to S0 with the same outputs as REQ-020.

Verification
- REQ-024 The bench SHALL check: reset=1 with TA=1 and TB=0 -> LA=00, LB=10 within the reset pulse, before any clock edge.
- REQ-025 The bench SHALL check: release reset, TA=1 held for 5 cycles -> LA=00, LB=10 throughout.
- REQ-026 The bench SHALL check: from S0, TA=0 -> after edge 1, LA=01 and LB=10; after edge 2, LA=10 and LB=00 (default YELLOW_CYCLES).
- REQ-027 The bench SHALL check: in S2, TB=1 held for 3 cycles -> LA=10, LB=00; then TB=0 -> after edge 1, LA=10 and LB=01; after edge 2, LA=00 and LB=10.
- REQ-028 The bench SHALL check: drive to S2, then assert reset between clock edges -> LA=00, LB=10 immediately, confirming the reset is asynchronous.
- REQ-029 The bench SHALL check: with YELLOW_CYCLES=3 and TA=0 in S0 -> LA=01 for exactly 3 cycles, then LA=10, LB=00; at every sample, at least one of LA or LB equals 10.

Source files
------------

// File: rtl/traffick_lights_fsm.sv
// -----------------------------------------------------------------------------
// traffick_lights_fsm
//
// Two-street traffic light controller built as a Moore FSM. Street A keeps its
// green while its sensor reports traffic. When A goes quiet, the controller
// steps A through yellow to red and hands green to street B. Street B keeps
// green while its own sensor reports traffic, then steps through yellow back to
// A. Each yellow phase lasts YELLOW_CYCLES clocks.
//
// Parameters
//   YELLOW_CYCLES : clocks spent in each yellow phase (1..255)
//
// Ports
//   clk    in   1  clock, rising-edge active
//   reset  in   1  asynchronous, active-high; forces A green / B red at once
//   TA     in   1  street A traffic sensor (1 = traffic present)
//   TB     in   1  street B traffic sensor (1 = traffic present)
//   LA     out  2  street A light (00 green, 01 yellow, 10 red)
//   LB     out  2  street B light (00 green, 01 yellow, 10 red)
// -----------------------------------------------------------------------------
module traffick_lights_fsm #(
    parameter int YELLOW_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       TA,
    input  logic       TB,
    output logic [1:0] LA,
    output logic [1:0] LB
);

    localparam logic [1:0] GREEN  = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] RED    = 2'b10;

    // Value loaded into the yellow down-counter when a yellow phase starts.
    // The phase ends on the cycle the counter reads zero, so loading N-1
    // yields exactly N cycles of yellow.
    localparam logic [7:0] YELLOW_LOAD = 8'(YELLOW_CYCLES - 1);

    // Sparse 3-bit encoding: the unused codes give a well-defined recovery
    // path back to S0 should the state register ever be upset.
    typedef enum logic [2:0] {
        S0 = 3'b000,   // A green,  B red
        S1 = 3'b001,   // A yellow, B red
        S2 = 3'b010,   // A red,    B green
        S3 = 3'b100    // A red,    B yellow
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [7:0] cnt;
    logic [7:0] next_cnt;

    // A sensor only counts as "traffic present" when it is a clean 1; an
    // unknown value is read as no traffic so the state never picks up X.
    function automatic logic sensed(input logic s);
        return (s === 1'b1);
    endfunction

    // State and counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S0;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        next_state = S0;
        next_cnt   = cnt;
        case (state)
            S0: begin
                if (sensed(TA)) begin
                    next_state = S0;
                end else begin
                    next_state = S1;
                    next_cnt   = YELLOW_LOAD;
                end
            end
            S1: begin
                if (cnt == 8'd0) begin
                    next_state = S2;
                end else begin
                    next_state = S1;
                    next_cnt   = cnt - 8'd1;
                end
            end
            S2: begin
                if (sensed(TB)) begin
                    next_state = S2;
                end else begin
                    next_state = S3;
                    next_cnt   = YELLOW_LOAD;
                end
            end
            S3: begin
                if (cnt == 8'd0) begin
                    next_state = S0;
                end else begin
                    next_state = S3;
                    next_cnt   = cnt - 8'd1;
                end
            end
            default: begin
                next_state = S0;
                next_cnt   = '0;
            end
        endcase
    end

    // Light decode from the state register only. Illegal codes show the S0
    // pattern so at most one street is ever non-red.
    always_comb begin
        LA = GREEN;
        LB = RED;
        case (state)
            S0: begin
                LA = GREEN;
                LB = RED;
            end
            S1: begin
                LA = YELLOW;
                LB = RED;
            end
            S2: begin
                LA = RED;
                LB = GREEN;
            end
            S3: begin
                LA = RED;
                LB = YELLOW;
            end
            default: begin
                LA = GREEN;
                LB = RED;
            end
        endcase
    end

endmodule

// File: tb/tb_traffick_lights_fsm.sv
// -----------------------------------------------------------------------------
// Testbench for traffick_lights_fsm. Two instances share clock and reset: one
// with the default yellow length and one with YELLOW_CYCLES = 3. Expected light
// pairs are queued when stimulus is applied and compared after the edge.
// -----------------------------------------------------------------------------
module tb_traffick_lights_fsm;

    localparam logic [3:0] OUT_S0 = 4'b0010;  // LA green,  LB red
    localparam logic [3:0] OUT_S1 = 4'b0110;  // LA yellow, LB red
    localparam logic [3:0] OUT_S2 = 4'b1000;  // LA red,    LB green
    localparam logic [3:0] OUT_S3 = 4'b1001;  // LA red,    LB yellow

    logic       clk;
    logic       reset;
    logic       ta1, tb1, ta3, tb3;
    logic [1:0] la1, lb1, la3, lb3;

    int check_cnt = 0;
    int pass_cnt  = 0;

    logic [7:0] sb[$];

    traffick_lights_fsm u_dut1 (
        .clk   (clk),
        .reset (reset),
        .TA    (ta1),
        .TB    (tb1),
        .LA    (la1),
        .LB    (lb1)
    );

    traffick_lights_fsm #(.YELLOW_CYCLES(3)) u_dut3 (
        .clk   (clk),
        .reset (reset),
        .TA    (ta3),
        .TB    (tb3),
        .LA    (la3),
        .LB    (lb3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        check_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %b required %b at %0t", tag, obs, exp, $time);
        end
    endtask

    // At least one light of a pair must be red (10).
    function automatic logic [3:0] one_red(input logic [1:0] la, input logic [1:0] lb);
        return {3'b000, (la == 2'b10) || (lb == 2'b10)};
    endfunction

    // Queue the expected outputs for both instances, clock once, then compare.
    task automatic tick(input string tag, input logic [3:0] e1, input logic [3:0] e3);
        logic [7:0] exp;
        sb.push_back({e1, e3});
        @(posedge clk);
        #1;
        exp = sb.pop_front();
        check_eq({tag, "_y1"}, {la1, lb1}, exp[7:4]);
        check_eq({tag, "_y3"}, {la3, lb3}, exp[3:0]);
        check_eq({tag, "_excl_y1"}, one_red(la1, lb1), 4'b0001);
        check_eq({tag, "_excl_y3"}, one_red(la3, lb3), 4'b0001);
    endtask

    // Immediate (no edge) comparison of both instances against the S0 pattern.
    task automatic check_now(input string tag);
        check_eq({tag, "_y1"}, {la1, lb1}, OUT_S0);
        check_eq({tag, "_y3"}, {la3, lb3}, OUT_S0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        ta1 = 1'b1; tb1 = 1'b0;
        ta3 = 1'b1; tb3 = 1'b0;

        // Reset seen before any clock edge.
        #1 reset = 1'b1;
        #2 check_now("rst_async");

        // Reset held across an edge with sensors asking to move.
        ta1 = 1'b0; tb1 = 1'b1; ta3 = 1'b0;
        tick("rst_hold", OUT_S0, OUT_S0);
        ta1 = 1'b1; ta3 = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        // A traffic present: stay green on A.
        for (int i = 0; i < 5; i++) tick("s0_hold", OUT_S0, OUT_S0);

        // A goes quiet: one yellow cycle, then B green.
        ta1 = 1'b0;
        tick("to_s1", OUT_S1, OUT_S0);
        ta1 = 1'b1;
        tb1 = 1'b1;
        tick("to_s2", OUT_S2, OUT_S0);
        for (int i = 0; i < 3; i++) tick("s2_hold", OUT_S2, OUT_S0);
        tb1 = 1'b0;
        tick("to_s3", OUT_S3, OUT_S0);
        tick("to_s0", OUT_S0, OUT_S0);
        tick("s0_back", OUT_S0, OUT_S0);

        // Reach S2 again, then reset between edges.
        ta1 = 1'b0;
        tick("again_s1", OUT_S1, OUT_S0);
        tick("again_s2", OUT_S2, OUT_S0);
        #2 reset = 1'b1;
        #1 check_now("rst_mid_s2");
        ta1 = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tick("after_rst", OUT_S0, OUT_S0);

        // Three-cycle yellow instance: full cycle.
        ta3 = 1'b0;
        tb3 = 1'b1;
        for (int i = 0; i < 3; i++) tick("y3_s1", OUT_S0, OUT_S1);
        tick("y3_s2", OUT_S0, OUT_S2);
        ta3 = 1'b1;
        tick("y3_s2_hold", OUT_S0, OUT_S2);
        tb3 = 1'b0;
        for (int i = 0; i < 3; i++) tick("y3_s3", OUT_S0, OUT_S3);
        tick("y3_s0", OUT_S0, OUT_S0);
        tick("y3_s0_hold", OUT_S0, OUT_S0);

        // Reset in the middle of a yellow count, then a full-length yellow.
        ta3 = 1'b0;
        tick("y3_mid_s1", OUT_S0, OUT_S1);
        tick("y3_mid_s1b", OUT_S0, OUT_S1);
        #2 reset = 1'b1;
        #1 check_now("rst_mid_yellow");
        ta3 = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tick("y3_after_rst", OUT_S0, OUT_S0);
        ta3 = 1'b0;
        for (int i = 0; i < 3; i++) tick("y3_reload_s1", OUT_S0, OUT_S1);
        tb3 = 1'b1;
        tick("y3_reload_s2", OUT_S0, OUT_S2);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
